// File: rtl/jogo_memoria_pkg.sv
// Shared state codes and helpers for the parametrised memory-game engine.
// Pure declarations: no logic, no latency, no flow control.
package jogo_memoria_pkg;

    localparam logic [4:0] S_INICIAL    = 5'b00000;
    localparam logic [4:0] S_PREPARA    = 5'b00001;
    localparam logic [4:0] S_MOSTRA     = 5'b00011;
    localparam logic [4:0] S_APAGA      = 5'b00101;
    localparam logic [4:0] S_ESPERA     = 5'b00111;
    localparam logic [4:0] S_COMPARA    = 5'b01001;
    localparam logic [4:0] S_PROX       = 5'b01011;
    localparam logic [4:0] S_FIM_RODADA = 5'b01101;
    localparam logic [4:0] S_ESCRITA    = 5'b01110;
    localparam logic [4:0] S_TIMEOUT    = 5'b01111;
    localparam logic [4:0] S_GANHOU     = 5'b10000;
    localparam logic [4:0] S_PERDEU     = 5'b10001;

    // Counter width for a modulus, never narrower than one bit.
    function automatic int largura(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Buttons are at most 8 wide, so callers zero-extend into this.
    function automatic logic eh_one_hot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/contador_param.sv
// Modulus counter with clear > load > enable priority and a terminal-count flag.
// Count visible one cycle after enable; no backpressure.
module contador_param
    import jogo_memoria_pkg::*;
#(
    parameter int MODULO = 16,
    parameter int W      = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic         en_i,
    input  logic [W-1:0] ld_val_i,
    output logic [W-1:0] q_o,
    output logic         fim_o
);

    localparam logic [W-1:0] ULTIMO = W'(MODULO - 1);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i)
            q_d = '0;
        else if (ld_i)
            q_d = ld_val_i;
        else if (en_i)
            q_d = (q_q == ULTIMO) ? '0 : q_q + W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q_o   = q_q;
    assign fim_o = (q_q == ULTIMO);

endmodule

// File: rtl/jogo_memoria_param.sv
// Memory-game engine: shows the first R stored one-hot plays, then checks R presses.
// Presses act one cycle after the button edge; the player is never stalled, only timed out.
module jogo_memoria_param
    import jogo_memoria_pkg::*;
#(
    parameter int N_BOTOES     = 4,
    parameter int PROFUNDIDADE = 16,
    parameter int T_LED        = 1000,
    parameter int T_GAP        = 500,
    parameter int T_TIMEOUT    = 5000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              jogar,
    input  logic [1:0]                        configuracao,
    input  logic [N_BOTOES-1:0]               botoes,
    input  logic                              carga_we,
    input  logic [$clog2(PROFUNDIDADE)-1:0]   carga_end,
    input  logic [N_BOTOES-1:0]               carga_dado,
    output logic [N_BOTOES-1:0]               leds,
    output logic                              pronto,
    output logic                              ganhou,
    output logic                              perdeu,
    output logic                              timeout,
    output logic [4:0]                        db_estado,
    output logic [$clog2(PROFUNDIDADE):0]     db_rodada,
    output logic [$clog2(PROFUNDIDADE)-1:0]   db_endereco
);

    localparam int AW    = $clog2(PROFUNDIDADE);
    localparam int RW    = AW + 1;
    localparam int T_MAX = (T_LED > T_GAP) ? T_LED : T_GAP;
    localparam int TW    = largura(T_MAX);
    localparam int OW    = largura(T_TIMEOUT);

    logic [4:0]          estado_q, estado_d;
    logic [1:0]          cfg_q, cfg_d;
    logic                botao_ant_q, press_q, jogar_ant_q;
    logic [N_BOTOES-1:0] captura_q;
    logic [N_BOTOES-1:0] mem [PROFUNDIDADE];

    logic          tmr_clr, tmr_en, to_clr, end_clr, end_ld, end_en, rod_ld, rod_en;
    logic [TW-1:0] tmr_q;
    logic [OW-1:0] to_q;
    logic [AW-1:0] end_q, end_val;
    logic [RW-1:0] rodada_q;
    logic          to_fim, rod_fim, tmr_fim_unused, end_fim_unused;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [N_BOTOES-1:0] mem_wdado;

    logic borda_botao, jogar_borda, ultimo, acerto, captura_ok;

    assign borda_botao = (|botoes) && !botao_ant_q;
    assign jogar_borda = jogar && !jogar_ant_q;
    assign ultimo      = ({1'b0, end_q} == (rodada_q - RW'(1)));
    assign captura_ok  = eh_one_hot(8'(captura_q));
    assign acerto      = captura_ok && (captura_q == mem[end_q]);

    contador_param #(.MODULO(T_MAX), .W(TW)) u_tmr_led (
        .clock(clock), .reset(reset), .clr_i(tmr_clr), .ld_i(1'b0), .en_i(tmr_en),
        .ld_val_i('0), .q_o(tmr_q), .fim_o(tmr_fim_unused)
    );

    contador_param #(.MODULO(T_TIMEOUT), .W(OW)) u_tmr_timeout (
        .clock(clock), .reset(reset), .clr_i(to_clr), .ld_i(1'b0), .en_i(1'b1),
        .ld_val_i('0), .q_o(to_q), .fim_o(to_fim)
    );

    contador_param #(.MODULO(PROFUNDIDADE), .W(AW)) u_cnt_end (
        .clock(clock), .reset(reset), .clr_i(end_clr), .ld_i(end_ld), .en_i(end_en),
        .ld_val_i(end_val), .q_o(end_q), .fim_o(end_fim_unused)
    );

    contador_param #(.MODULO(PROFUNDIDADE + 1), .W(RW)) u_cnt_rodada (
        .clock(clock), .reset(reset), .clr_i(1'b0), .ld_i(rod_ld), .en_i(rod_en),
        .ld_val_i(RW'(1)), .q_o(rodada_q), .fim_o(rod_fim)
    );

    always_comb begin
        estado_d  = estado_q;
        cfg_d     = cfg_q;
        tmr_clr   = 1'b1;
        tmr_en    = 1'b0;
        to_clr    = 1'b1;
        end_clr   = 1'b0;
        end_ld    = 1'b0;
        end_en    = 1'b0;
        end_val   = '0;
        rod_ld    = 1'b0;
        rod_en    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = end_q;
        mem_wdado = captura_q;
        leds      = '0;
        case (estado_q)
            S_INICIAL: begin
                if (carga_we) begin
                    mem_we    = 1'b1;
                    mem_waddr = carga_end;
                    mem_wdado = carga_dado;
                end
                if (jogar_borda) estado_d = S_PREPARA;
            end
            S_PREPARA: begin
                cfg_d    = configuracao;
                rod_ld   = 1'b1;
                end_clr  = 1'b1;
                estado_d = configuracao[0] ? S_ESCRITA : S_MOSTRA;
            end
            S_MOSTRA: begin
                leds    = mem[end_q];
                tmr_en  = 1'b1;
                tmr_clr = (tmr_q == TW'(T_LED - 1));
                if (tmr_clr) estado_d = S_APAGA;
            end
            S_APAGA: begin
                tmr_en  = 1'b1;
                tmr_clr = (tmr_q == TW'(T_GAP - 1));
                if (tmr_clr) begin
                    if (ultimo) begin
                        end_clr  = 1'b1;
                        estado_d = S_ESPERA;
                    end else begin
                        end_en   = 1'b1;
                        estado_d = S_MOSTRA;
                    end
                end
            end
            // A press arriving in the expiry cycle wins over the timeout.
            S_ESPERA: begin
                to_clr = press_q;
                if (press_q)
                    estado_d = S_COMPARA;
                else if (cfg_q[1] && to_fim)
                    estado_d = S_TIMEOUT;
            end
            S_COMPARA: begin
                leds = captura_q;
                if (!acerto)
                    estado_d = S_PERDEU;
                else if (ultimo)
                    estado_d = S_FIM_RODADA;
                else
                    estado_d = S_PROX;
            end
            S_PROX: begin
                end_en   = 1'b1;
                estado_d = S_ESPERA;
            end
            S_FIM_RODADA: begin
                if (rod_fim) begin
                    estado_d = S_GANHOU;
                end else begin
                    rod_en = 1'b1;
                    if (cfg_q[0]) begin
                        end_ld   = 1'b1;
                        end_val  = rodada_q[AW-1:0];
                        estado_d = S_ESCRITA;
                    end else begin
                        end_clr  = 1'b1;
                        estado_d = S_MOSTRA;
                    end
                end
            end
            S_ESCRITA: begin
                to_clr = press_q;
                if (press_q) begin
                    if (captura_ok) begin
                        mem_we   = 1'b1;
                        end_clr  = 1'b1;
                        estado_d = S_MOSTRA;
                    end else begin
                        estado_d = S_PERDEU;
                    end
                end else if (cfg_q[1] && to_fim) begin
                    estado_d = S_TIMEOUT;
                end
            end
            S_GANHOU, S_PERDEU, S_TIMEOUT: begin
                if (jogar_borda) estado_d = S_PREPARA;
            end
            default: estado_d = S_INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q    <= S_INICIAL;
            cfg_q       <= '0;
            botao_ant_q <= 1'b0;
            press_q     <= 1'b0;
            captura_q   <= '0;
            jogar_ant_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            cfg_q       <= cfg_d;
            botao_ant_q <= |botoes;
            press_q     <= borda_botao;
            jogar_ant_q <= jogar;
            if (borda_botao) captura_q <= botoes;
        end
    end

    // Sequence memory survives reset so a preloaded game can be replayed.
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdado;
    end

    assign pronto      = (estado_q == S_GANHOU) || (estado_q == S_PERDEU) || (estado_q == S_TIMEOUT);
    assign ganhou      = (estado_q == S_GANHOU);
    assign perdeu      = (estado_q == S_PERDEU);
    assign timeout     = (estado_q == S_TIMEOUT);
    assign db_estado   = estado_q;
    assign db_rodada   = rodada_q;
    assign db_endereco = end_q;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Directed bench for jogo_memoria_param; LED displays are checked against a queue
// of expected plays filled as each game is started.
module tb_jogo_memoria_param;

    localparam int N = 4, D = 4, TL = 4, TG = 2, TT = 20;

    localparam logic [4:0] E_INICIAL = 5'b00000;
    localparam logic [4:0] E_PREPARA = 5'b00001;
    localparam logic [4:0] E_MOSTRA  = 5'b00011;
    localparam logic [4:0] E_APAGA   = 5'b00101;
    localparam logic [4:0] E_ESPERA  = 5'b00111;
    localparam logic [4:0] E_COMPARA = 5'b01001;
    localparam logic [4:0] E_ESCRITA = 5'b01110;
    localparam logic [4:0] E_TIMEOUT = 5'b01111;
    localparam logic [4:0] E_GANHOU  = 5'b10000;
    localparam logic [4:0] E_PERDEU  = 5'b10001;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         jogar = 1'b0;
    logic [1:0]   configuracao = 2'b00;
    logic [N-1:0] botoes = '0;
    logic         carga_we = 1'b0;
    logic [1:0]   carga_end = '0;
    logic [N-1:0] carga_dado = '0;
    logic [N-1:0] leds;
    logic         pronto, ganhou, perdeu, timeout;
    logic [4:0]   db_estado;
    logic [2:0]   db_rodada;
    logic [1:0]   db_endereco;

    int           nvec = 0;
    int           nfail = 0;
    logic [N-1:0] fila[$];
    logic [N-1:0] seq [4];
    bit           mon_on = 1'b0;
    logic [4:0]   est_ant = '0;
    int           run = 0;

    jogo_memoria_param #(
        .N_BOTOES(N), .PROFUNDIDADE(D), .T_LED(TL), .T_GAP(TG), .T_TIMEOUT(TT)
    ) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .configuracao(configuracao),
        .botoes(botoes), .carga_we(carga_we), .carga_end(carga_end), .carga_dado(carga_dado),
        .leds(leds), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
        .db_estado(db_estado), .db_rodada(db_rodada), .db_endereco(db_endereco)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_est(input logic [4:0] e, input int budget, input string tag);
        int k = 0;
        while (db_estado !== e && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk(tag, db_estado, e);
    endtask

    task automatic apertar(input logic [N-1:0] v);
        botoes = v;
        tick(2);
        botoes = '0;
        tick(2);
    endtask

    task automatic iniciar(input logic [1:0] cfg);
        configuracao = cfg;
        jogar = 1'b1;
        tick();
        jogar = 1'b0;
    endtask

    // Round r displays plays 0..r-1 of the preloaded sequence.
    task automatic empilhar(input int nr);
        for (int r = 1; r <= nr; r++)
            for (int i = 0; i < r; i++) fila.push_back(seq[i]);
    endtask

    task automatic jogar_rodadas(input int nr);
        for (int r = 1; r <= nr; r++) begin
            wait_est(E_ESPERA, 200, "espera_rodada");
            for (int i = 0; i < r; i++) apertar(seq[i]);
        end
    endtask

    task automatic partida_vencedora();
        empilhar(4);
        iniciar(2'b00);
        jogar_rodadas(4);
        wait_est(E_GANHOU, 20, "estado_ganhou");
        chk("ganhou_flag", ganhou, 1'b1);
        chk("ganhou_pronto", pronto, 1'b1);
        chk("ganhou_perdeu", perdeu, 1'b0);
        chk("ganhou_rodada", db_rodada, 3'd4);
    endtask

    // Scoreboard: each MOSTRA entry pops one expected play; also times MOSTRA/APAGA.
    always @(negedge clock) begin
        if (db_estado != est_ant) begin
            if (mon_on && est_ant == E_MOSTRA) chk("dur_mostra", run, TL);
            if (mon_on && est_ant == E_APAGA) chk("dur_apaga", run, TG);
            if (mon_on && db_estado == E_MOSTRA) begin
                if (fila.size() == 0) begin
                    nvec++;
                    nfail++;
                    $error("FAIL led_inesperado: observed %b expected none", leds);
                end else begin
                    chk("led_mostra", leds, fila.pop_front());
                end
            end
            run = 1;
        end else begin
            run++;
        end
        est_ant = db_estado;
    end

    initial begin
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        #1 reset = 1'b0;
        #2;
        chk("rst_estado", db_estado, E_INICIAL);
        chk("rst_leds", leds, 4'b0000);
        chk("rst_flags", {pronto, ganhou, perdeu, timeout}, 4'b0000);
        chk("rst_rodada", db_rodada, 3'd0);
        chk("rst_endereco", db_endereco, 2'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            carga_we = 1'b1;
            carga_end = 2'(i);
            carga_dado = seq[i];
            tick();
        end
        carga_we = 1'b0;
        mon_on = 1'b1;

        partida_vencedora();

        // Wrong play in round 2.
        empilhar(2);
        iniciar(2'b00);
        jogar_rodadas(1);
        wait_est(E_ESPERA, 200, "espera_r2");
        apertar(4'b0001);
        botoes = 4'b0100;
        wait_est(E_COMPARA, 10, "estado_compara");
        chk("compara_eco", leds, 4'b0100);
        tick();
        chk("perdeu_estado", db_estado, E_PERDEU);
        chk("perdeu_flag", perdeu, 1'b1);
        chk("perdeu_ganhou", ganhou, 1'b0);
        chk("perdeu_pronto", pronto, 1'b1);
        botoes = '0;
        tick(2);

        // Timeout enabled: expires on the 20th idle cycle.
        fila.push_back(4'b0001);
        iniciar(2'b10);
        wait_est(E_ESPERA, 50, "espera_to");
        tick(TT - 1);
        chk("to_ainda_espera", db_estado, E_ESPERA);
        tick();
        chk("to_estado", db_estado, E_TIMEOUT);
        chk("to_flag", timeout, 1'b1);
        chk("to_pronto", pronto, 1'b1);

        // Timeout disabled: idle 100 cycles, stray jogar and preload ignored.
        fila.push_back(4'b0001);
        iniciar(2'b00);
        wait_est(E_ESPERA, 50, "espera_idle");
        carga_we = 1'b1;
        carga_end = 2'd0;
        carga_dado = 4'b1000;
        jogar = 1'b1;
        tick();
        carga_we = 1'b0;
        jogar = 1'b0;
        tick(99);
        chk("idle_espera", db_estado, E_ESPERA);
        chk("idle_pronto", pronto, 1'b0);
        apertar(4'b0011);
        chk("nao_onehot_perdeu", db_estado, E_PERDEU);
        chk("nao_onehot_flag", perdeu, 1'b1);

        // Press landing in the expiry cycle beats the timeout.
        fila.push_back(4'b0001);
        iniciar(2'b10);
        wait_est(E_ESPERA, 50, "espera_simult");
        mon_on = 1'b0;
        tick(TT - 2);
        botoes = 4'b0001;
        tick();
        chk("simult_espera", db_estado, E_ESPERA);
        tick();
        chk("simult_compara", db_estado, E_COMPARA);
        botoes = '0;

        // Reset pulled low mid-display.
        wait_est(E_MOSTRA, 20, "mostra_pre_reset");
        chk("mostra_leds_acesos", leds, 4'b0001);
        #2 reset = 1'b0;
        #1;
        chk("rst_meio_estado", db_estado, E_INICIAL);
        chk("rst_meio_leds", leds, 4'b0000);
        chk("rst_meio_rodada", db_rodada, 3'd0);
        chk("rst_meio_end", db_endereco, 2'd0);
        tick();
        reset = 1'b1;
        fila.delete();
        tick();
        mon_on = 1'b1;

        partida_vencedora();

        // Write mode: sequence grows from the player's presses.
        fila.push_back(4'b0010);
        iniciar(2'b01);
        wait_est(E_ESCRITA, 5, "escrita_r1");
        apertar(4'b0010);
        wait_est(E_ESPERA, 50, "espera_w1");
        chk("w1_rodada", db_rodada, 3'd1);
        fila.push_back(4'b0010);
        fila.push_back(4'b1000);
        apertar(4'b0010);
        wait_est(E_ESCRITA, 10, "escrita_r2");
        chk("w2_endereco", db_endereco, 2'd1);
        chk("w2_rodada", db_rodada, 3'd2);
        apertar(4'b1000);
        wait_est(E_ESPERA, 50, "espera_w2");
        apertar(4'b0010);
        apertar(4'b1000);
        wait_est(E_ESCRITA, 10, "escrita_r3");
        chk("w3_endereco", db_endereco, 2'd2);
        chk("w3_rodada", db_rodada, 3'd3);

        chk("fila_vazia", fila.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
